// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute pipe: widths, op encodings, S1 payload.
package alu_pkg;

   localparam int unsigned W    = 16;
   localparam int unsigned NREG = 8;
   localparam int unsigned RW   = $clog2(NREG);
   localparam int unsigned OPW  = 3;
   localparam int unsigned SHW  = $clog2(W);

   typedef enum logic [OPW-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SLL = 3'd4,
      OP_SRL = 3'd5,
      OP_SRA = 3'd6,
      OP_SLT = 3'd7
   } op_e;

   // Operand register contents between issue and execute
   typedef struct packed {
      op_e           op;
      logic [RW-1:0] rd;
      logic [W-1:0]  i0;
      logic [W-1:0]  i1;
   } s1_t;

endpackage

// File: rtl/alu.sv
// 16-bit combinational ALU; carry is meaningful for add/sub only.
module alu
   import alu_pkg::*;
(
   input  op_e          op,
   input  logic [W-1:0] i0,
   input  logic [W-1:0] i1,
   output logic [W-1:0] o,
   output logic         carry
);

   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [SHW-1:0] shamt;

   // Result select; sub and slt share the i0 + ~i1 + 1 adder
   always_comb begin
      o     = '0;
      carry = 1'b0;
      shamt = i1[SHW-1:0];
      sum   = {1'b0, i0} + {1'b0, i1};
      diff  = {1'b0, i0} + {1'b0, ~i1} + (W+1)'(1);
      case (op)
         OP_ADD: begin
            o     = sum[W-1:0];
            carry = sum[W];
         end
         OP_SUB: begin
            o     = diff[W-1:0];
            carry = diff[W];
         end
         OP_AND:  o = i0 & i1;
         OP_OR:   o = i0 | i1;
         OP_SLL:  o = i0 << shamt;
         OP_SRL:  o = i0 >> shamt;
         OP_SRA:  o = W'($signed(i0) >>> shamt);
         OP_SLT:  o = W'(diff[W-1]);
         default: o = '0;
      endcase
   end

endmodule

// File: rtl/alu_regfile.sv
// 8x16 register file: two async read ports, one sync write port, r0 reads zero.
module alu_regfile
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [RW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [RW-1:0] ra1,
   input  logic [RW-1:0] ra2,
   output logic [W-1:0]  rd1_c,
   output logic [W-1:0]  rd2_c
);

   logic [W-1:0] regs [NREG];

   // Write port; r0 is never written so it stays at its reset value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // Async read ports with r0 hardwired to zero
   always_comb begin
      rd1_c = (ra1 == '0) ? '0 : regs[ra1];
      rd2_c = (ra2 == '0) ? '0 : regs[ra2];
   end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage issue/execute/writeback pipe around the 16-bit alu.
// Build option: ALU_EXEC_FWD_EN forwards the S1 alu result to a dependent
// instruction at issue; without it a dependent instruction is interlocked
// for one cycle and reads the written-back value.
module alu_exec_pipe
   import alu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in_op,
   input  logic [RW-1:0]  in_rd,
   input  logic [RW-1:0]  in_rs1,
   input  logic [RW-1:0]  in_rs2,
   input  logic           in_use_imm,
   input  logic [W-1:0]   in_imm,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_result,
   output logic [RW-1:0]  out_rd,
   output logic           out_carry,
   output logic           flag_c
);

   s1_t          s1_q;
   logic         s1_valid;
   logic         s1_adv;
   logic         accept;
   logic         dep;
   logic         haz_rs1;
   logic         haz_rs2;
   logic [W-1:0] rf_rd1;
   logic [W-1:0] rf_rd2;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] alu_o;
   logic         alu_carry;

   alu_regfile u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (s1_adv),
      .wa    (s1_q.rd),
      .wd    (alu_o),
      .ra1   (in_rs1),
      .ra2   (in_rs2),
      .rd1_c (rf_rd1),
      .rd2_c (rf_rd2)
   );

   alu u_alu (
      .op    (s1_q.op),
      .i0    (s1_q.i0),
      .i1    (s1_q.i1),
      .o     (alu_o),
      .carry (alu_carry)
   );

   // Handshake, hazard detection and operand selection for the offered instruction
   always_comb begin
      s1_adv  = s1_valid && (!out_valid || out_ready);
      dep     = s1_valid && (s1_q.rd != '0);
      haz_rs1 = dep && (s1_q.rd == in_rs1);
      haz_rs2 = dep && !in_use_imm && (s1_q.rd == in_rs2);
`ifdef ALU_EXEC_FWD_EN
      in_ready = !s1_valid || s1_adv;
      op_a     = haz_rs1 ? alu_o : rf_rd1;
      op_b     = in_use_imm ? in_imm : (haz_rs2 ? alu_o : rf_rd2);
`else
      in_ready = (!s1_valid || s1_adv) && !(in_valid && (haz_rs1 || haz_rs2));
      op_a     = rf_rd1;
      op_b     = in_use_imm ? in_imm : rf_rd2;
`endif
      accept = in_valid && in_ready;
   end

   // S1 operand register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_q     <= '{op: op_e'(in_op), rd: in_rd, i0: op_a, i1: op_b};
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 output register and sticky carry flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
         out_carry  <= 1'b0;
         flag_c     <= 1'b0;
      end else if (s1_adv) begin
         out_valid  <= 1'b1;
         out_result <= alu_o;
         out_rd     <= s1_q.rd;
         out_carry  <= alu_carry;
         if ((s1_q.op == OP_ADD) || (s1_q.op == OP_SUB)) flag_c <= alu_carry;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe: reference model computes expected
// results at accept time, a monitor compares as results leave the pipe.
module tb_alu_exec_pipe;

`ifdef ALU_EXEC_FWD_EN
   localparam int FWD = 1;
`else
   localparam int FWD = 0;
`endif

   typedef struct packed {
      logic [15:0] res;
      logic [2:0]  rd;
      logic        c;
      logic        f;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [2:0]  in_rd;
   logic [2:0]  in_rs1;
   logic [2:0]  in_rs2;
   logic        in_use_imm;
   logic [15:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_rd;
   logic        out_carry;
   logic        flag_c;

   int   tests = 0;
   int   fails = 0;
   int   model_r [8];
   bit   model_f;
   exp_t q [$];
   bit   bp_rand;
   int   stalls;
   bit   prev_stall;
   int   prev_data;

   always #5 clk = ~clk;

   alu_exec_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_use_imm (in_use_imm),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_rd     (out_rd),
      .out_carry  (out_carry),
      .flag_c     (flag_c)
   );

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) model_r[i] = 0;
      model_f = 1'b0;
   endfunction

   // Architectural model: instructions execute strictly in order
   function automatic void model_exec(input int op, input int rd, input int rs1,
                                      input int rs2, input bit ui, input int imm);
      int   a, b, sh, t, res, sa;
      bit   c;
      exp_t e;
      a  = model_r[rs1];
      b  = ui ? imm : model_r[rs2];
      sh = b % 16;
      c  = 1'b0;
      res = 0;
      case (op)
         0: begin t = a + b; res = t % 65536; c = (t >= 65536); end
         1: begin t = a + (65535 - b) + 1; res = t % 65536; c = (t >= 65536); end
         2: res = a & b;
         3: res = a | b;
         4: res = (a << sh) & 32'hFFFF;
         5: res = a >> sh;
         6: begin sa = (a >= 32768) ? a - 65536 : a; res = (sa >>> sh) & 32'hFFFF; end
         default: res = ((a - b) & 32'h8000) != 0 ? 1 : 0;
      endcase
      if (op <= 1) model_f = c;
      if (rd != 0) model_r[rd] = res;
      e.res = 16'(res);
      e.rd  = 3'(rd);
      e.c   = c;
      e.f   = model_f;
      q.push_back(e);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         in_valid = 1'b0;
      end
   endtask

   // Offer one instruction and hold it until accepted; counts in_ready=0 cycles
   task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                        input bit ui, input int imm);
      step();
      in_valid   = 1'b1;
      in_op      = 3'(op);
      in_rd      = 3'(rd);
      in_rs1     = 3'(rs1);
      in_rs2     = 3'(rs2);
      in_use_imm = ui;
      in_imm     = 16'(imm);
      stalls     = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (in_ready) begin
            model_exec(op, rd, rs1, rs2, ui, imm);
            return;
         end
         stalls++;
         step();
      end
      check("issue_timeout", 0, 1);
   endtask

   task automatic issue_rand();
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 65535));
   endtask

   // Monitor: hold-stability while stalled, scoreboard compare on each transfer
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'({out_result, out_rd, out_carry}), prev_data);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", int'(out_result), -1);
            end else begin
               e = q.pop_front();
               check("result", int'(out_result), int'(e.res));
               check("rd", int'(out_rd), int'(e.rd));
               check("carry", int'(out_carry), int'(e.c));
               check("flag_c", int'(flag_c), int'(e.f));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = int'({out_result, out_rd, out_carry});
      end
   end

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_op      = '0;
      in_rd      = '0;
      in_rs1     = '0;
      in_rs2     = '0;
      in_use_imm = 1'b0;
      in_imm     = '0;
      out_ready  = 1'b1;
      bp_rand    = 1'b0;
      prev_stall = 1'b0;
      prev_data  = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_result", int'(out_result), 0);
      check("rst_out_rd", int'(out_rd), 0);
      check("rst_out_carry", int'(out_carry), 0);
      check("rst_flag_c", int'(flag_c), 0);
      check("rst_in_ready", int'(in_ready), 1);

      // Directed arithmetic, carry flag, shifts, slt and r0 behaviour
      issue(0, 1, 0, 0, 1, 16'hFFFF);
      issue(0, 2, 0, 0, 1, 16'h0001);
      issue(0, 3, 1, 2, 0, 0);
      issue(1, 4, 2, 1, 0, 0);
      issue(2, 5, 1, 0, 1, 16'h00F0);
      issue(0, 7, 0, 0, 1, 16'h8000);
      issue(6, 6, 7, 0, 1, 4);
      issue(5, 6, 7, 0, 1, 4);
      issue(4, 5, 2, 0, 1, 15);
      issue(0, 4, 0, 0, 1, 2);
      issue(7, 3, 2, 4, 0, 0);
      issue(0, 0, 0, 0, 1, 16'h1234);
      issue(3, 1, 0, 0, 0, 0);
      idle(4);

      // Dependent back-to-back pair
      issue(0, 1, 0, 0, 1, 5);
      issue(0, 2, 1, 1, 0, 0);
      check("chain_stalls", stalls, FWD ? 0 : 1);
      idle(4);

      // Backpressure: out_ready low for 4 cycles with 3 independent instructions
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join_none
      issue(0, 3, 0, 0, 1, 16'h0011);
      issue(0, 4, 0, 0, 1, 16'h0022);
      issue(0, 5, 0, 0, 1, 16'h0033);
      check("bp_in_ready_drop", int'(stalls > 0), 1);
      idle(6);

      // Random traffic with random backpressure
      bp_rand = 1'b1;
      repeat (300) issue_rand();
      repeat (15) issue_rand();

      // Reset mid-stream
      bp_rand = 1'b0;
      step();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      q.delete();
      model_reset();
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_result", int'(out_result), 0);
      check("midrst_flag_c", int'(flag_c), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      for (int i = 1; i < 8; i++) issue(3, i, i, 0, 1, 0);

      bp_rand = 1'b1;
      repeat (300) issue_rand();
      bp_rand = 1'b0;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
      check("drain_queue_empty", q.size(), 0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_exec_pipe.md
# alu_exec_pipe

Two-stage issue/execute/writeback stage that sits directly upstream of the 16-bit `alu` and consumes its result. Accepts register-form or immediate-form ALU instructions over a valid/ready handshake and reads operands from an internal 8×16 register file. Drives `alu` op/i0/i1, writes the result back and streams it out with backpressure. It also maintains a carry flag.

## Interface
- `NREG`, 8: register count; architectural, fixed.
- `W`, 16: datapath width; must match `alu`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: instruction accepted when `in_valid && in_ready`.
- `in_op` input 3: ALU op. 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 slt.
- `in_rd`, `in_rs1`, `in_rs2` input 3 each: register indices.
- `in_use_imm` input 1: 1 selects `in_imm` as i1 instead of rs2.
- `in_imm` input 16: immediate operand.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output 16: ALU result.
- `out_rd` output 3: destination index.
- `out_carry` output 1: `alu` carry for this op; 0 for ops 2–7.
- `flag_c` output 1: sticky carry flag.

## Operation
- r0 reads as 0. Writes to r0 are discarded; the result is still emitted on the out stream.
- **S1 (operand register)** loads on accept with:
  - op, rd
  - i0 = R[rs1]
  - i1 = `in_use_imm ? in_imm : R[rs2]`
- The `alu` instance is driven combinationally from S1.
- **S2 (output register)** loads {alu o, carry, rd} when S1 advances.
- Advance rules:
  - `s1_adv = s1_valid && (!s2_valid || out_ready)`
  - `in_ready = !s1_valid || s1_adv`
- Writeback: R[rd] ← alu o on the same edge S1 advances (rd≠0). S2 needs no forwarding.
- Carry flag: `flag_c` ← alu carry on S1 advance, for op 0/1 only. Other ops leave it unchanged.
- Shift amount is i1[3:0]; the upper bits of i1 are ignored.
- slt result = {15'b0, (i0−i1)[15]}.
- Width rules:
  - add/sub wrap modulo 2^16.
  - The carry of sub is the raw carry-out of i0 + ~i1 + 1, so 1 means no borrow.
- Hazard, case S1.rd == rs1, or rs2 without `in_use_imm` (rd≠0): depends on the configuration macro.
- Simultaneous `out_ready`, S1 advance and a new accept form a full-throughput pipeline, one instruction per cycle.

## Timing
- Instruction accepted at edge N:
  - S1 valid in cycle N+1.
  - Regfile write and S2 load at edge N+1 if S2 is free.
  - `out_valid` high from cycle N+2.
- Latency: 2 cycles accept→result.
- `out_valid` with `out_ready`=0 holds `out_result`/`out_rd`/`out_carry` stable and stalls S1, and therefore `in_ready`.
- Reset (`rst_n`=0 at an edge):
  - `s1_valid`=0, `s2_valid`=0, `out_valid`=0.
  - `out_result`=0, `out_rd`=0, `out_carry`=0, `flag_c`=0.
  - R1–R7 = 0.
- Reset mid-operation discards in-flight instructions with no writeback. `in_ready`=1 in the first cycle after reset.

## Configuration
- `ALU_EXEC_FWD_EN` defined:
  - On a hazard, the operand is taken from the combinational alu o of S1.
  - Accept is permitted only when S1 advances that edge, which `in_ready` already guarantees.
  - No stall.
- Undefined:
  - On a hazard, `in_ready` is forced 0 for that cycle (interlock). The instruction is accepted the next cycle from the updated regfile.
  - Dependent back-to-back costs 1 bubble.

## Structure
- `alu_pkg` holds:
  - op encodings (`OP_ADD`…`OP_SLT`)
  - `W`, `NREG`
  - an S1 struct typedef {op, rd, i0, i1}
- Sub-module `alu_regfile`: 8×16, two async read ports, one sync write port, r0 hardwired to zero.
- `alu` is instantiated unchanged.

## Test plan
- Load r1=0xFFFF (or r0,imm) and r2=0x0001; add r3,r1,r2 → out_result 0x0000, out_carry 1, flag_c 1.
- sub r4,r2,r1 (1−0xFFFF) → 0x0002, carry 0. Then and r5,r1,imm 0x00F0 → 0x00F0, with flag_c still 0.
- sra r6,r7(=0x8000),imm 4 → 0xF800. srl → 0x0800. slt on 1,2 → 0x0001.
- Dependent chain `add r1,r0,imm 5` then `add r2,r1,r1` issued back-to-back:
  - r2 result 0x000A in both configurations.
  - With FWD_EN: no `in_ready` drop.
  - Without: exactly one `in_ready`=0 cycle.
- `out_ready` held 0 for 4 cycles with 3 instructions issued:
  - Outputs stay stable.
  - `in_ready` drops after S1 fills.
  - All 3 results emerge in order, none lost.
- Write to r0 with imm 0x1234: result 0x1234 is emitted, and a later read of r0 gives 0. `rst_n` low mid-stream: `out_valid`=0 next cycle, all registers 0, no stale result emitted.
